// File: rtl/controlador_reconstrucao_caminho.sv
`default_nettype none
// ============================================================================
//  Module   : controlador_reconstrucao_caminho
//  Purpose  : Walks the predecessor RAM from destination back to source onto a
//             LIFO, then streams the path source-first over valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module controlador_reconstrucao_caminho #(
   parameter int ADDR_WIDTH = 10,
   parameter int MAX_PATH   = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start_in,
   input  logic [ADDR_WIDTH-1:0]       top_fonte_in,
   input  logic [ADDR_WIDTH-1:0]       top_destino_in,
   output logic                        mem_read_en_out,
   output logic [ADDR_WIDTH-1:0]       mem_read_addr_out,
   input  logic [ADDR_WIDTH-1:0]       mem_read_data_in,
   output logic                        caminho_valid_out,
   input  logic                        caminho_ready_in,
   output logic [ADDR_WIDTH-1:0]       caminho_data_out,
   output logic                        caminho_last_out,
   output logic [$clog2(MAX_PATH):0]   caminho_len_out,
   output logic                        busy_out,
   output logic                        done_out,
   output logic                        erro_out
);

   localparam int LEN_W = $clog2(MAX_PATH) + 1;
   localparam int IDX_W = (MAX_PATH > 1) ? $clog2(MAX_PATH) : 1;
   localparam logic [LEN_W-1:0] c_max_path = LEN_W'(MAX_PATH);
   localparam logic [LEN_W-1:0] c_one      = LEN_W'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LER    = 3'd1,
      S_ESPERA = 3'd2,
      S_EMIT   = 3'd3,
      S_DONE   = 3'd4,
      S_ERRO   = 3'd5
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_WIDTH-1:0] r_fonte;
   logic [ADDR_WIDTH-1:0] r_cur;
   logic [ADDR_WIDTH-1:0] r_stack [MAX_PATH];
   logic [LEN_W-1:0]      r_sp;
   logic [LEN_W-1:0]      r_len;
   logic                  r_erro;
   logic [LEN_W-1:0]      w_top;
   logic                  w_accept;
   logic                  w_full;
   logic                  w_hit;
   logic                  w_pop;
   logic                  w_push_pred;

   assign w_top       = r_sp - c_one;
   assign w_accept    = (r_state == S_IDLE) && start_in;
   assign w_full      = (r_len == c_max_path);
   assign w_hit       = (mem_read_data_in == r_fonte);
   assign w_pop       = (r_state == S_EMIT) && caminho_ready_in;
   assign w_push_pred = (r_state == S_ESPERA) && !w_full;

   assign busy_out        = (r_state != S_IDLE);
   assign erro_out        = r_erro;
   assign caminho_len_out = r_len;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next            = r_state;
      mem_read_en_out   = 1'b0;
      mem_read_addr_out = '0;
      caminho_valid_out = 1'b0;
      caminho_data_out  = '0;
      caminho_last_out  = 1'b0;
      done_out          = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_in)
               w_next = (top_destino_in == top_fonte_in) ? S_EMIT : S_LER;
         end
         S_LER: begin
            mem_read_en_out   = 1'b1;
            mem_read_addr_out = r_cur;
            w_next            = S_ESPERA;
         end
         S_ESPERA: begin
            if (w_full)     w_next = S_ERRO;
            else if (w_hit) w_next = S_EMIT;
            else            w_next = S_LER;
         end
         S_EMIT: begin
            caminho_valid_out = 1'b1;
            caminho_data_out  = r_stack[w_top[IDX_W-1:0]];
            caminho_last_out  = (r_sp == c_one);
            if (caminho_ready_in && (r_sp == c_one)) w_next = S_DONE;
         end
         S_DONE: begin
            done_out = 1'b1;
            w_next   = S_IDLE;
         end
         S_ERRO: begin
            done_out = 1'b1;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // During the walk r_sp equals r_len, so a non-full push always lands in range.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fonte <= '0;
         r_cur   <= '0;
         r_sp    <= '0;
         r_len   <= '0;
         r_erro  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_fonte <= top_fonte_in;
            r_cur   <= top_destino_in;
            r_sp    <= c_one;
            r_len   <= c_one;
            r_erro  <= 1'b0;
         end else if (w_push_pred) begin
            r_cur <= mem_read_data_in;
            r_sp  <= r_sp + c_one;
            r_len <= r_len + c_one;
         end else if (w_pop) begin
            r_sp <= w_top;
         end else if (r_state == S_ERRO) begin
            r_erro <= 1'b1;
            r_sp   <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept)
         r_stack[0] <= top_destino_in;
      else if (w_push_pred)
         r_stack[r_sp[IDX_W-1:0]] <= mem_read_data_in;
   end

endmodule
`default_nettype wire

// File: tb/tb_controlador_reconstrucao_caminho.sv
`default_nettype none
// ============================================================================
//  Module   : tb_controlador_reconstrucao_caminho
//  Purpose  : Scoreboard bench: expected beats/RAM reads queued at start,
//             popped and compared as the controller produces them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_controlador_reconstrucao_caminho;

   localparam int AW = 10;
   localparam int MP = 64;
   localparam int LW = 7;

   typedef struct packed {
      logic [AW-1:0] d;
      logic          l;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_in;
   logic [AW-1:0] fonte, destino;
   logic          mem_read_en;
   logic [AW-1:0] mem_read_addr;
   logic [AW-1:0] mem_data;
   logic          valid, ready, last;
   logic [AW-1:0] data;
   logic [LW-1:0] len;
   logic          busy, done, erro;

   logic [AW-1:0] pred [1024];
   beat_t         exp_q [$];
   logic [AW-1:0] addr_q [$];

   int n_checks = 0, n_fail = 0;
   int cyc = 0, start_cyc = 0, lat = -1, done_cnt = 0, beats = 0;
   int ready_mode = 0, rp = 0;
   bit armed = 0, have_stall = 0;
   logic [AW-1:0] st_data;
   logic          st_last;

   controlador_reconstrucao_caminho #(.ADDR_WIDTH(AW), .MAX_PATH(MP)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start_in          (start_in),
      .top_fonte_in      (fonte),
      .top_destino_in    (destino),
      .mem_read_en_out   (mem_read_en),
      .mem_read_addr_out (mem_read_addr),
      .mem_read_data_in  (mem_data),
      .caminho_valid_out (valid),
      .caminho_ready_in  (ready),
      .caminho_data_out  (data),
      .caminho_last_out  (last),
      .caminho_len_out   (len),
      .busy_out          (busy),
      .done_out          (done),
      .erro_out          (erro)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_read_en) mem_data <= pred[mem_read_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Monitor: consumes the scoreboard queues as the DUT produces reads/beats.
   always @(negedge clk) begin
      logic [AW-1:0] a;
      beat_t         b;
      if (rst_n) begin
         if (done) done_cnt++;
         if (mem_read_en) begin
            if (addr_q.size() == 0) check("rd_unexpected", 1, 0);
            else begin
               a = addr_q.pop_front();
               check("rd_addr", mem_read_addr, a);
            end
         end
         if (valid) begin
            if (armed) begin lat = cyc - start_cyc; armed = 0; end
            if (have_stall) begin
               check("stall_data", data, st_data);
               check("stall_last", last, st_last);
            end
            if (ready) begin
               if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
               else begin
                  b = exp_q.pop_front();
                  check("beat_data", data, b.d);
                  check("beat_last", last, b.l);
               end
               beats++;
            end
         end
         have_stall = valid && !ready;
         st_data    = data;
         st_last    = last;
      end else begin
         have_stall = 0;
      end
   end

   initial begin
      ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (ready_mode == 0) ready = 1'b1;
         else begin
            case (rp % 4)
               0: ready = 1'b1;
               1: ready = 1'b0;
               2: ready = 1'b0;
               default: ready = 1'b1;
            endcase
            rp++;
         end
      end
   end

   task automatic queue_path(input logic [AW-1:0] f, input logic [AW-1:0] d,
                             output bit err, output int n_nodes);
      logic [AW-1:0] path [$];
      logic [AW-1:0] n;
      beat_t         b;
      err = 0;
      n   = d;
      path.push_back(d);
      while (n != f) begin
         addr_q.push_back(n);
         if (path.size() == MP) begin err = 1; break; end
         n = pred[n];
         path.push_back(n);
      end
      n_nodes = path.size();
      if (!err)
         for (int i = path.size() - 1; i >= 0; i--) begin
            b.d = path[i];
            b.l = (i == 0);
            exp_q.push_back(b);
         end
   endtask

   task automatic launch(input logic [AW-1:0] f, input logic [AW-1:0] d);
      @(posedge clk); #1;
      fonte = f; destino = d; start_in = 1'b1;
      start_cyc = cyc; armed = 1; lat = -1; beats = 0;
      @(posedge clk); #1;
      start_in = 1'b0;
   endtask

   task automatic do_path(input string name, input logic [AW-1:0] f,
                          input logic [AW-1:0] d, input bit inject);
      bit err;
      int n_nodes, t0, guard, h;
      queue_path(f, d, err, n_nodes);
      h  = n_nodes - 1;
      t0 = done_cnt;
      launch(f, d);
      if (inject) begin
         @(posedge clk); #1;
         fonte = 10'd9; destino = 10'd9; start_in = 1'b1;
         @(posedge clk); #1;
         start_in = 1'b0;
      end
      guard = 0;
      while (done_cnt == t0 && guard < 3000) begin @(posedge clk); guard++; end
      #1;
      check($sformatf("%s_timeout", name), guard < 3000, 1);
      check($sformatf("%s_busy_after_done", name), busy, 0);
      check($sformatf("%s_erro", name), erro, err);
      check($sformatf("%s_beats", name), beats, err ? 0 : n_nodes);
      check($sformatf("%s_exp_left", name), exp_q.size(), 0);
      check($sformatf("%s_rd_left", name), addr_q.size(), 0);
      if (!err) begin
         check($sformatf("%s_len", name), len, n_nodes);
         check($sformatf("%s_latency", name), (lat >= 1 + 2*h) && (lat <= 3 + 2*h), 1);
      end
      armed = 0;
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("%s_one_done", name), done_cnt, t0 + 1);
      check($sformatf("%s_erro_hold", name), erro, err);
      exp_q.delete();
      addr_q.delete();
   endtask

   initial begin
      bit err;
      int n_nodes, guard, t0;
      for (int i = 0; i < 1024; i++) pred[i] = '0;
      pred[5] = 10'd3; pred[3] = 10'd7; pred[7] = 10'd0;
      pred[2] = 10'd4; pred[4] = 10'd2;
      for (int i = 101; i <= 163; i++) pred[i] = AW'(i - 1);
      rst_n = 1'b0; start_in = 1'b0; fonte = '0; destino = '0;
      #2;
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_erro", erro, 0);
      check("rst_rden", mem_read_en, 0);
      check("rst_len", len, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      do_path("single", 10'd9, 10'd9, 0);
      do_path("chain", 10'd0, 10'd5, 0);
      ready_mode = 1; rp = 0;
      do_path("stall", 10'd0, 10'd5, 0);
      ready_mode = 0;
      do_path("loop_err", 10'd9, 10'd2, 0);
      do_path("busy_start", 10'd0, 10'd5, 1);
      do_path("full64", 10'd100, 10'd163, 0);
      do_path("over64", 10'd99, 10'd163, 0);

      // Abort during EMIT after two beats have been consumed.
      queue_path(10'd0, 10'd5, err, n_nodes);
      launch(10'd0, 10'd5);
      guard = 0;
      while (beats < 2 && guard < 200) begin @(posedge clk); guard++; end
      check("rst_mid_reach", guard < 200, 1);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_valid", valid, 0);
      check("rst_mid_last", last, 0);
      check("rst_mid_data", data, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_len", len, 0);
      exp_q.delete();
      addr_q.delete();
      armed = 0;
      t0 = done_cnt;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_mid_no_done", done_cnt, t0);
      do_path("post_rst", 10'd0, 10'd5, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      n_fail++;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
